// File: rtl/sram_arbiter_if.sv
// Signal bundle between the CPU strobe bus, the DMA req/ack master and the external SRAM pins.
// slave is the arbiter's view; master is the view of whatever drives the requests and models the SRAM.
interface sram_arbiter_if;
   logic [19:0] iCpuAddr;
   logic [7:0]  iCpuData;
   logic        iCpuRd;
   logic        iCpuWr;
   logic [7:0]  oCpuData;
   logic        oCpuBusy;
   logic        oCpuOvf;
   logic        iDmaReq;
   logic        iDmaWr;
   logic [19:0] iDmaAddr;
   logic [7:0]  iDmaData;
   logic        oDmaAck;
   logic [7:0]  oDmaData;
   logic [19:0] oSramA;
   logic [7:0]  oSramDOut;
   logic [7:0]  iSramDIn;
   logic        oSramDir;
   logic        oSramCe1;
   logic        oSramCe2;
   logic        oSramOe;
   logic        oSramWe;

   modport slave (
      input  iCpuAddr, iCpuData, iCpuRd, iCpuWr, iDmaReq, iDmaWr, iDmaAddr, iDmaData, iSramDIn,
      output oCpuData, oCpuBusy, oCpuOvf, oDmaAck, oDmaData,
      output oSramA, oSramDOut, oSramDir, oSramCe1, oSramCe2, oSramOe, oSramWe
   );

   modport master (
      output iCpuAddr, iCpuData, iCpuRd, iCpuWr, iDmaReq, iDmaWr, iDmaAddr, iDmaData, iSramDIn,
      input  oCpuData, oCpuBusy, oCpuOvf, oDmaAck, oDmaData,
      input  oSramA, oSramDOut, oSramDir, oSramCe1, oSramCe2, oSramOe, oSramWe
   );
endinterface

// File: rtl/sram_arbiter.sv
// CPU/DMA arbiter and sequencer for the external async SRAM; each access is ACCESS_CYCLES + 1 recovery cycle.
// CPU has a depth-1 pending slot (overflow is sticky); DMA holds its request until the one-cycle ack.
module sram_arbiter #(
   parameter int ACCESS_CYCLES = 2,
   parameter int DMA_MAX_WAIT  = 3
) (
   input logic           iClk,
   input logic           iRstN,
   sram_arbiter_if.slave bus
);
   localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam int WW = $clog2(DMA_MAX_WAIT + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);
   localparam logic [WW-1:0] MAX_WAIT = WW'(DMA_MAX_WAIT);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RECOVER = 2'd2} state_t;

   state_t        state_q;
   logic          owner_dma_q, wr_q, reload_q;
   logic [CW-1:0] cnt_q;
   logic [WW-1:0] waitcnt_q;
   logic          pend_q, pend_wr_q;
   logic [19:0]   pend_addr_q;
   logic [7:0]    pend_data_q;
   logic [19:0]   sram_a_q;
   logic [7:0]    sram_dout_q, cpu_data_q, dma_data_q;
   logic          dir_q, ce1_q, ce2_q, oe_q, we_q, dma_ack_q, busy_q, ovf_q;

   logic        strobe, cpu_req, dma_win, g_wr;
   logic [19:0] g_addr;
   logic [7:0]  g_data;

   // A strobe in the IDLE cycle itself is granted straight from the bus
   assign strobe  = bus.iCpuRd | bus.iCpuWr;
   assign cpu_req = pend_q | strobe;
   assign dma_win = bus.iDmaReq && (!cpu_req || (waitcnt_q >= MAX_WAIT));
   assign g_wr    = dma_win ? bus.iDmaWr   : (strobe ? bus.iCpuWr   : pend_wr_q);
   assign g_addr  = dma_win ? bus.iDmaAddr : (strobe ? bus.iCpuAddr : pend_addr_q);
   assign g_data  = dma_win ? bus.iDmaData : (strobe ? bus.iCpuData : pend_data_q);

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q     <= IDLE;
         owner_dma_q <= 1'b0;
         wr_q        <= 1'b0;
         reload_q    <= 1'b0;
         cnt_q       <= '0;
         waitcnt_q   <= '0;
         pend_q      <= 1'b0;
         pend_wr_q   <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         sram_a_q    <= '0;
         sram_dout_q <= '0;
         cpu_data_q  <= '0;
         dma_data_q  <= '0;
         dir_q       <= 1'b0;
         ce1_q       <= 1'b1;
         ce2_q       <= 1'b0;
         oe_q        <= 1'b1;
         we_q        <= 1'b1;
         dma_ack_q   <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         dma_ack_q <= 1'b0;
         if (strobe) begin
            pend_q      <= 1'b1;
            pend_wr_q   <= bus.iCpuWr;
            pend_addr_q <= bus.iCpuAddr;
            pend_data_q <= bus.iCpuData;
            if (pend_q) ovf_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               busy_q   <= cpu_req;
               reload_q <= 1'b0;
               if (dma_win || cpu_req) begin
                  state_q     <= ACCESS;
                  cnt_q       <= '0;
                  owner_dma_q <= dma_win;
                  wr_q        <= g_wr;
                  sram_a_q    <= g_addr;
                  ce1_q       <= 1'b0;
                  ce2_q       <= 1'b1;
                  oe_q        <= g_wr;
                  we_q        <= !g_wr;
                  dir_q       <= g_wr;
                  if (g_wr) sram_dout_q <= g_data;
                  if (dma_win) waitcnt_q <= '0;
                  else if (bus.iDmaReq && (waitcnt_q < MAX_WAIT)) waitcnt_q <= waitcnt_q + 1'b1;
               end
            end
            ACCESS: begin
               busy_q <= pend_q | strobe | !owner_dma_q;
               if (strobe && !owner_dma_q) reload_q <= 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_q <= RECOVER;
                  ce1_q   <= 1'b1;
                  ce2_q   <= 1'b0;
                  oe_q    <= 1'b1;
                  we_q    <= 1'b1;
                  if (owner_dma_q) begin
                     dma_ack_q <= 1'b1;
                     if (!wr_q) dma_data_q <= bus.iSramDIn;
                  end else begin
                     if (!wr_q) cpu_data_q <= bus.iSramDIn;
                     // A strobe that landed during this access keeps the slot pending
                     if (!strobe && !reload_q) pend_q <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RECOVER: begin
               busy_q  <= pend_q | strobe;
               dir_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.oCpuData  = cpu_data_q;
   assign bus.oCpuBusy  = busy_q;
   assign bus.oCpuOvf   = ovf_q;
   assign bus.oDmaAck   = dma_ack_q;
   assign bus.oDmaData  = dma_data_q;
   assign bus.oSramA    = sram_a_q;
   assign bus.oSramDOut = sram_dout_q;
   assign bus.oSramDir  = dir_q;
   assign bus.oSramCe1  = ce1_q;
   assign bus.oSramCe2  = ce2_q;
   assign bus.oSramOe   = oe_q;
   assign bus.oSramWe   = we_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with ACCESS_CYCLES = 2, DMA_MAX_WAIT = 3.
module tb_sram_arbiter;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   sram_arbiter_if bus();

   sram_arbiter #(.ACCESS_CYCLES(2), .DMA_MAX_WAIT(3)) dut (
      .iClk  (clk),
      .iRstN (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_A"},     32'(bus.oSramA), 0);
      chk({p, "_dout"},  32'(bus.oSramDOut), 0);
      chk({p, "_dir"},   32'(bus.oSramDir), 0);
      chk({p, "_ce1"},   32'(bus.oSramCe1), 1);
      chk({p, "_ce2"},   32'(bus.oSramCe2), 0);
      chk({p, "_oe"},    32'(bus.oSramOe), 1);
      chk({p, "_we"},    32'(bus.oSramWe), 1);
      chk({p, "_cpud"},  32'(bus.oCpuData), 0);
      chk({p, "_dmad"},  32'(bus.oDmaData), 0);
      chk({p, "_ack"},   32'(bus.oDmaAck), 0);
      chk({p, "_busy"},  32'(bus.oCpuBusy), 0);
      chk({p, "_ovf"},   32'(bus.oCpuOvf), 0);
      chk({p, "_state"}, 32'(dut.state_q), 0);
      chk({p, "_wait"},  32'(dut.waitcnt_q), 0);
   endtask

   initial begin
      rst_n        = 1'b1;
      bus.iCpuAddr = '0;
      bus.iCpuData = '0;
      bus.iCpuRd   = 1'b0;
      bus.iCpuWr   = 1'b0;
      bus.iDmaReq  = 1'b0;
      bus.iDmaWr   = 1'b0;
      bus.iDmaAddr = '0;
      bus.iDmaData = '0;
      bus.iSramDIn = '0;
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk_reset("por");
      @(negedge clk) rst_n = 1'b1;
      tick();

      // CPU read: strobe at t, OE low t+1..t+2, data at t+3, IDLE at t+4
      bus.iCpuAddr = 20'h12345;
      bus.iSramDIn = 8'hA5;
      bus.iCpuRd   = 1'b1;
      tick();
      bus.iCpuRd = 1'b0;
      chk("rd_oe1",  32'(bus.oSramOe), 0);
      chk("rd_addr", 32'(bus.oSramA), 'h12345);
      chk("rd_ce1",  32'(bus.oSramCe1), 0);
      chk("rd_ce2",  32'(bus.oSramCe2), 1);
      chk("rd_dir",  32'(bus.oSramDir), 0);
      chk("rd_busy", 32'(bus.oCpuBusy), 1);
      tick();
      chk("rd_oe2",  32'(bus.oSramOe), 0);
      chk("rd_we2",  32'(bus.oSramWe), 1);
      tick();
      chk("rd_data",  32'(bus.oCpuData), 'hA5);
      chk("rd_oeoff", 32'(bus.oSramOe), 1);
      chk("rd_ceoff", 32'(bus.oSramCe1), 1);
      tick();
      chk("rd_idle",    32'(dut.state_q), 0);
      chk("rd_busyoff", 32'(bus.oCpuBusy), 0);

      // CPU write 0x3C to 0xF0000
      bus.iCpuAddr = 20'hF0000;
      bus.iCpuData = 8'h3C;
      bus.iCpuWr   = 1'b1;
      tick();
      bus.iCpuWr = 1'b0;
      chk("wr_we1",   32'(bus.oSramWe), 0);
      chk("wr_dir1",  32'(bus.oSramDir), 1);
      chk("wr_dout",  32'(bus.oSramDOut), 'h3C);
      chk("wr_oe1",   32'(bus.oSramOe), 1);
      chk("wr_addr",  32'(bus.oSramA), 'hF0000);
      tick();
      chk("wr_we2",   32'(bus.oSramWe), 0);
      chk("wr_dir2",  32'(bus.oSramDir), 1);
      chk("wr_oe2",   32'(bus.oSramOe), 1);
      tick();
      chk("wr_we3",   32'(bus.oSramWe), 1);
      chk("wr_dir3",  32'(bus.oSramDir), 1);
      chk("wr_oe3",   32'(bus.oSramOe), 1);
      chk("wr_ce3",   32'(bus.oSramCe1), 1);
      chk("wr_addr3", 32'(bus.oSramA), 'hF0000);
      tick();
      chk("wr_dir4",  32'(bus.oSramDir), 0);

      // DMA read in flight; CPU read strobe lands in its first ACCESS cycle
      bus.iDmaReq  = 1'b1;
      bus.iDmaWr   = 1'b0;
      bus.iDmaAddr = 20'h00ABC;
      bus.iSramDIn = 8'h5A;
      tick();
      chk("dma_addr", 32'(bus.oSramA), 'h00ABC);
      chk("dma_oe",   32'(bus.oSramOe), 0);
      bus.iCpuAddr = 20'h00111;
      bus.iCpuRd   = 1'b1;
      tick();
      bus.iCpuRd = 1'b0;
      chk("dma_cpubusy", 32'(bus.oCpuBusy), 1);
      tick();
      chk("dma_ack",   32'(bus.oDmaAck), 1);
      chk("dma_data",  32'(bus.oDmaData), 'h5A);
      chk("dma_recce", 32'(bus.oSramCe1), 1);
      tick();
      bus.iDmaReq  = 1'b0;
      bus.iSramDIn = 8'hC3;
      chk("dma_ackoff", 32'(bus.oDmaAck), 0);
      chk("dma_idle",   32'(dut.state_q), 0);
      tick();
      chk("cpu2_addr", 32'(bus.oSramA), 'h00111);
      chk("cpu2_oe",   32'(bus.oSramOe), 0);
      tick();
      tick();
      chk("cpu2_lat_data", 32'(bus.oCpuData), 'hC3);
      tick();

      // DMA held high; CPU strobes every 4 cycles win three times, then DMA is forced
      bus.iDmaReq  = 1'b1;
      bus.iDmaWr   = 1'b1;
      bus.iDmaAddr = 20'h55555;
      bus.iDmaData = 8'h77;
      bus.iSramDIn = 8'h11;
      for (int k = 0; k < 3; k++) begin
         bus.iCpuAddr = 20'(k + 1);
         bus.iCpuRd   = 1'b1;
         tick();
         bus.iCpuRd = 1'b0;
         chk("starve_cpu_addr", 32'(bus.oSramA), 32'(k + 1));
         chk("starve_cpu_oe",   32'(bus.oSramOe), 0);
         tick();
         tick();
         tick();
      end
      chk("starve_wait3", 32'(dut.waitcnt_q), 3);
      bus.iCpuAddr = 20'h00004;
      bus.iSramDIn = 8'h99;
      bus.iCpuRd   = 1'b1;
      tick();
      bus.iCpuRd = 1'b0;
      chk("forced_addr", 32'(bus.oSramA), 'h55555);
      chk("forced_we",   32'(bus.oSramWe), 0);
      chk("forced_dout", 32'(bus.oSramDOut), 'h77);
      chk("forced_wait", 32'(dut.waitcnt_q), 0);
      chk("forced_busy", 32'(bus.oCpuBusy), 1);
      tick();
      tick();
      chk("forced_ack", 32'(bus.oDmaAck), 1);
      chk("forced_ovf", 32'(bus.oCpuOvf), 0);
      tick();
      bus.iDmaReq = 1'b0;
      tick();
      chk("buffered_addr", 32'(bus.oSramA), 'h00004);
      chk("buffered_oe",   32'(bus.oSramOe), 0);
      chk("buffered_wait", 32'(dut.waitcnt_q), 0);
      tick();
      tick();
      chk("buffered_data", 32'(bus.oCpuData), 'h99);
      chk("buffered_ovf",  32'(bus.oCpuOvf), 0);
      tick();

      // Two CPU strobes while a DMA write is in flight: second overwrites the slot
      bus.iDmaReq  = 1'b1;
      bus.iDmaWr   = 1'b1;
      bus.iDmaAddr = 20'h0AAAA;
      bus.iDmaData = 8'h12;
      tick();
      bus.iCpuAddr = 20'h01000;
      bus.iCpuRd   = 1'b1;
      tick();
      bus.iCpuRd   = 1'b0;
      bus.iCpuWr   = 1'b1;
      bus.iCpuAddr = 20'h02000;
      bus.iCpuData = 8'h34;
      tick();
      bus.iCpuWr = 1'b0;
      chk("ovf_set", 32'(bus.oCpuOvf), 1);
      chk("ovf_ack", 32'(bus.oDmaAck), 1);
      tick();
      bus.iDmaReq = 1'b0;
      tick();
      chk("ovf_addr1", 32'(bus.oSramA), 'h02000);
      chk("ovf_we",    32'(bus.oSramWe), 0);
      chk("ovf_dout",  32'(bus.oSramDOut), 'h34);
      tick();
      chk("ovf_addr2", 32'(bus.oSramA), 'h02000);
      chk("ovf_oe",    32'(bus.oSramOe), 1);
      tick();
      tick();
      chk("ovf_hold",  32'(bus.oCpuOvf), 1);
      chk("ovf_busy",  32'(bus.oCpuBusy), 0);
      chk("ovf_idle",  32'(dut.state_q), 0);

      // Asynchronous reset in the middle of a DMA write
      bus.iDmaReq  = 1'b1;
      bus.iDmaWr   = 1'b1;
      bus.iDmaAddr = 20'h0F0F0;
      bus.iDmaData = 8'hEE;
      tick();
      chk("arst_pre_we", 32'(bus.oSramWe), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_we",  32'(bus.oSramWe), 1);
      chk("arst_ce1", 32'(bus.oSramCe1), 1);
      chk("arst_ce2", 32'(bus.oSramCe2), 0);
      chk("arst_dir", 32'(bus.oSramDir), 0);
      chk("arst_ack", 32'(bus.oDmaAck), 0);
      chk("arst_ovf", 32'(bus.oCpuOvf), 0);
      bus.iDmaReq = 1'b0;
      tick();
      tick();
      chk("arst_ack_held", 32'(bus.oDmaAck), 0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk_reset("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
